// File: rtl/tanh_pwl_eval.sv
// tanh_pwl_eval: 3-stage piecewise-linear tanh evaluator, y = slope*|x|*sign(x) + intercept in sign-magnitude Q format.
module tanh_pwl_eval #(
  parameter int FRAC_BITS = 15,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic [31:0]      lut_x,
  input  logic [31:0]      lut_slope,
  input  logic [31:0]      lut_intercept,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] sample_cnt
);
  logic               en, v1, v2;
  logic [31:0]        x1, s1, i1;
  logic [62:0]        prod, shifted;
  logic [30:0]        p_mag;
  logic signed [31:0] p_s, ic_s, p2, ic2;
  logic signed [33:0] sum;
  logic [33:0]        mag;
  logic [31:0]        y;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign lut_x    = in_data;
  always_comb begin
    prod    = {31'b0, s1} * {32'b0, x1[30:0]};
    shifted = prod >> FRAC_BITS;
    p_mag   = |shifted[62:31] ? 31'h7FFFFFFF : shifted[30:0];
    p_s     = x1[31] ? -$signed({1'b0, p_mag}) : $signed({1'b0, p_mag});
    ic_s    = i1[31] ? -$signed({1'b0, i1[30:0]}) : $signed({1'b0, i1[30:0]});
    sum     = {{2{p2[31]}}, p2} + {{2{ic2[31]}}, ic2};
    mag     = sum[33] ? -sum : sum;
    y       = {sum[33], |mag[33:31] ? 31'h7FFFFFFF : mag[30:0]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      x1        <= '0;
      s1        <= '0;
      i1        <= '0;
      p2        <= '0;
      ic2       <= '0;
      out_data  <= '0;
    end else if (en) begin
      v1        <= in_valid;
      x1        <= in_data;
      s1        <= lut_slope;
      i1        <= lut_intercept;
      v2        <= v1;
      p2        <= p_s;
      ic2       <= ic_s;
      out_valid <= v2;
      out_data  <= y;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sample_cnt <= '0;
    else if (out_valid && out_ready) sample_cnt <= sample_cnt + 1'b1;
  end
endmodule

// File: tb/tb_tanh_pwl_eval.sv
// tb_tanh_pwl_eval: directed vectors for tanh_pwl_eval with hand-computed results.
module tb_tanh_pwl_eval;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic        in_ready, out_valid;
  logic [31:0] in_data = 0, lut_slope = 0, lut_intercept = 0, lut_x, out_data;
  logic [15:0] sample_cnt, ecnt = 0;
  logic [2:0]  mv = 0;
  logic        en_m;
  int vectors = 0, errors = 0, sent = 0, rcvd = 0, c = 0, bad = 0;

  tanh_pwl_eval dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .lut_x(lut_x), .lut_slope(lut_slope), .lut_intercept(lut_intercept),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic one(input string tag, input logic [31:0] x, s, i, y);
    in_valid = 1; in_data = x; lut_slope = s; lut_intercept = i; out_ready = 1;
    #1 check({tag, "_lutx"}, lut_x, x);
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk); #1 check({tag, "_early"}, 32'(out_valid), 0);
    @(posedge clk); #1 check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_y"}, out_data, y);
    @(posedge clk); #1 ecnt++;
    check({tag, "_cnt"}, 32'(sample_cnt), 32'(ecnt));
  endtask

  initial begin
    #12;
    check("rst_ready", 32'(in_ready), 1);
    check("rst_ovalid", 32'(out_valid), 0);
    check("rst_data", out_data, 0);
    check("rst_cnt", 32'(sample_cnt), 0);
    @(posedge clk); #1 rst = 0;
    one("pos", 32'h00002000, 28468, 908, 32'h00001F59);
    one("neg", 32'h80002000, 28468, 32'h8000038C, 32'h80001F59);
    one("nzero", 32'h80000000, 32101, 0, 32'h00000000);
    one("flat", 32'h00040000, 0, 32768, 32'h00008000);
    one("sat", 32'h7FFFFFFF, 32'hFFFFFFFF, 0, 32'h7FFFFFFF);
    one("nsat", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000005, 32'hFFFFFFFF);
    one("icnz", 32'h00008000, 32768, 32'h80000000, 32'h00008000);
    one("cancel", 32'h00008000, 32768, 32'h80008000, 32'h00000000);
    // Stream with slope 1.0: sample k = 0x100*(k+1), intercept k -> y = 0x101*k + 0x100
    while (rcvd < 8 && c < 200) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      in_valid = sent < 8; in_data = 32'h100 * (sent + 1); lut_slope = 32768; lut_intercept = sent;
      #1 en_m = !mv[2] || out_ready;
      check("s_ready", 32'(in_ready), 32'(en_m));
      check("s_ovalid", 32'(out_valid), 32'(mv[2]));
      if (mv[2] && out_ready) begin
        check("s_data", out_data, 32'h101 * rcvd + 32'h100);
        rcvd++;
      end
      @(posedge clk);
      if (en_m) begin
        mv = {mv[1:0], in_valid};
        if (in_valid) sent++;
      end
      #1 c++;
    end
    in_valid = 0; out_ready = 1; ecnt += 16'd8;
    check("s_rcvd", rcvd, 8);
    check("s_cnt", 32'(sample_cnt), 32'(ecnt));
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_data = 32'h2000 + k; lut_slope = 28468; lut_intercept = 908;
      @(posedge clk); #1;
    end
    in_valid = 0; rst = 1;
    #1 check("r_ovalid", 32'(out_valid), 0);
    check("r_cnt", 32'(sample_cnt), 0);
    check("r_ready", 32'(in_ready), 1);
    @(posedge clk); #1 rst = 0; ecnt = 0;
    repeat (6) begin
      @(posedge clk); #1 if (out_valid) bad++;
    end
    check("r_quiet", bad, 0);
    one("post", 32'h00002000, 28468, 908, 32'h00001F59);
    in_valid = 1; out_ready = 1;
    repeat (65534) @(posedge clk);
    #1 in_valid = 0;
    repeat (3) @(posedge clk);
    #1 ecnt += 16'd65534;
    check("w_full", 32'(sample_cnt), 32'h0000FFFF);
    one("wrap", 32'h00002000, 28468, 908, 32'h00001F59);
    check("w_zero", 32'(sample_cnt), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
